// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        KP_IDLE    = 2'd0,
        KP_PRESSED = 2'd1,
        KP_LOCKED  = 2'd2
    } kp_state_e;

    function automatic logic one_hot16(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    function automatic key_code_t low_index(input logic [15:0] v);
        key_code_t idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = key_code_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix pins plus the debounced key outputs consumed by control logic.
// Outputs are level/pulse signals; key_valid is a single-cycle strobe with no ready.
interface keypad_scan_if;
    import keypad_pkg::*;

    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_map;
    key_code_t   key_code;
    logic        key_valid;
    logic        key_held;
    logic [1:0]  state;

    modport master (output col, input row, key_map, key_code, key_valid, key_held, state);
    modport slave  (input col, output row, key_map, key_code, key_valid, key_held, state);
endinterface

// File: rtl/keypad_debounce.sv
// Full-scan snapshot debouncer: key_map follows the snapshot only after it has
// been identical for DEBOUNCE_SCANS consecutive scans.
module keypad_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] snapshot,
    input  logic        eos,
    output logic [15:0] key_map
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [CW-1:0] stable_cnt;
    logic [15:0]   prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt <= '0;
            prev       <= '0;
            key_map    <= '0;
        end else begin
            if (eos) begin
                if (snapshot == prev) begin
                    if (stable_cnt != CW'(DEBOUNCE_SCANS)) stable_cnt <= stable_cnt + 1'b1;
                end else begin
                    stable_cnt <= CW'(1);
                    prev       <= snapshot;
                end
            end
            // prev is frozen while the count is saturated, so this is a clean copy.
            if (stable_cnt == CW'(DEBOUNCE_SCANS)) key_map <= prev;
        end
    end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad row scanner with column synchronizer, debounce and press-event FSM.
// Define KEYPAD_REPEAT_EN to add auto-repeat of a held single key.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 40,
    parameter int REPEAT_PERIOD  = 10
) (
    input  logic clk_4000,
    input  logic rst,
    keypad_scan_if.slave kp
);
    localparam int PW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [1:0] ST_IDLE    = KP_IDLE;
    localparam logic [1:0] ST_PRESSED = KP_PRESSED;
    localparam logic [1:0] ST_LOCKED  = KP_LOCKED;

    if (SETTLE_CYCLES < 2) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 2");
    end
    if (DEBOUNCE_SCANS < 2) begin : g_bad_debounce
        $error("DEBOUNCE_SCANS must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [KP_COLS-1:0] col_s1, col_s2, pressed;
    logic [PW-1:0]      phase;
    logic [1:0]         r;
    logic               last_phase, eos;
    logic [11:0]        snap;
    logic [15:0]        snap_full, key_map, key_mask;
    logic [1:0]         state;
    key_code_t          key_code;
    logic               key_valid, key_held, same_key, rep_fire;

    always_ff @(posedge clk_4000 or posedge rst) begin
        if (rst) begin
            col_s1 <= 4'b1111;
            col_s2 <= 4'b1111;
        end else begin
            col_s1 <= kp.col;
            col_s2 <= col_s1;
        end
    end

    assign pressed    = ~col_s2;
    assign last_phase = (phase == PW'(SETTLE_CYCLES));
    assign eos        = last_phase && (r == 2'(KP_ROWS - 1));
    // The last row goes straight into the snapshot so the debouncer sees it this cycle.
    assign snap_full  = {pressed, snap};

    always_ff @(posedge clk_4000 or posedge rst) begin
        if (rst) begin
            phase <= '0;
            r     <= '0;
            snap  <= '0;
        end else if (last_phase) begin
            phase <= '0;
            r     <= r + 2'd1;
            case (r)
                2'd0:    snap[3:0]  <= pressed;
                2'd1:    snap[7:4]  <= pressed;
                2'd2:    snap[11:8] <= pressed;
                default: ;
            endcase
        end else begin
            phase <= phase + 1'b1;
        end
    end

    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk      (clk_4000),
        .rst      (rst),
        .snapshot (snap_full),
        .eos      (eos),
        .key_map  (key_map)
    );

    assign key_mask = 16'd1 << key_code;
    assign same_key = (key_map == key_mask);

`ifdef KEYPAD_REPEAT_EN
    logic [15:0] rep_cnt, rep_target;
    logic        rep_armed;

    assign rep_target = rep_armed ? 16'(REPEAT_PERIOD) : 16'(REPEAT_DELAY);
    assign rep_fire   = (state == ST_PRESSED) && same_key && eos &&
                        (rep_cnt + 16'd1 >= rep_target);

    always_ff @(posedge clk_4000 or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (state != ST_PRESSED || !same_key) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (eos) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 16'd1;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk_4000 or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_map != 16'd0) begin
                        if (one_hot16(key_map)) begin
                            state     <= ST_PRESSED;
                            key_code  <= low_index(key_map);
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end else begin
                            state <= ST_LOCKED;
                        end
                    end
                end
                ST_PRESSED: begin
                    if (key_map == 16'd0) begin
                        state    <= ST_IDLE;
                        key_held <= 1'b0;
                    end else if (!same_key) begin
                        state    <= ST_LOCKED;
                        key_held <= 1'b0;
                    end else if (rep_fire) begin
                        key_valid <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (key_map == 16'd0) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign kp.row       = ~(4'b0001 << r);
    assign kp.key_map   = key_map;
    assign kp.key_code  = key_code;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;
    assign kp.state     = state;
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- 4x4 matrix keypad scanner; the input-side counterpart of the LED dot-matrix row-scan driver.
- Drives one active-low row at a time and samples the active-low columns, which are pulled up.
- Assembles a 16-bit key snapshot per scan, debounces it, and emits single-key press events (code + 1-cycle valid) to game/control logic.
- Shares the slow scan clock domain with the display driver.

Parameters:
- SETTLE_CYCLES, 2, clocks each row is driven before its columns are sampled (>=2, covers the 2-FF sync); row period = SETTLE_CYCLES+1.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan snapshots required to update the debounced map (>=2).
- REPEAT_DELAY, 40, scans a key must stay held before the first auto-repeat (feature only).
- REPEAT_PERIOD, 10, scans between auto-repeats (feature only).

Ports:
- clk_4000  in  1  scan clock
- rst  in  1  reset, asynchronous, active-high
- col  in  4  column sense, active low, asynchronous to clk_4000
- row  out  4  row drive, one-hot active low
- key_map  out  16  debounced pressed map, bit {r,c} = 4*r+c
- key_code  out  4  {row[1:0], col[1:0]} of the last accepted key
- key_valid  out  1  1-cycle pulse per accepted press
- key_held  out  1  high while the accepted key stays debounced-pressed

Behaviour:
- One clock domain; reset asynchronous, active-high.
- Reset values: row=4'b1110, key_map=0, key_code=0, key_valid=0, key_held=0. All counters, the snapshot and sync flops clear; the event FSM goes to IDLE.
- col passes through a 2-FF synchronizer (reset to 4'b1111) and is inverted internally, so 1 = pressed.
- Scan counter: row index r (0..3) and phase (0..SETTLE_CYCLES).
  - row[r]=0, all others 1.
  - On the last phase, synced ~col is written to snap[4r+3:4r].
  - r then advances, wrapping 3->0.
  - Scan period is 4*(SETTLE_CYCLES+1) = 12 clocks at default.
- End of scan (r=3, last phase), using the completed snapshot, including the bits captured that cycle:
  - If snapshot == prev, stable_cnt increments, saturating at DEBOUNCE_SCANS.
  - Otherwise stable_cnt=1 and prev=snapshot.
  - When stable_cnt reaches DEBOUNCE_SCANS, key_map<=prev, registered one cycle after the end of scan.
- Event FSM, evaluated on key_map:
  - IDLE: key_map==0 stays. One-hot -> PRESSED, key_code<=index, key_valid=1 for exactly 1 cycle, key_held=1. Multi-bit -> LOCKED with no event.
  - PRESSED: key_map unchanged stays. key_map==0 -> IDLE, key_held=0. Any other value (second key added, or a different key) -> LOCKED, key_held=0, no event.
  - LOCKED: waits for key_map==0, then -> IDLE. A new press must always start from all-released.
- key_code holds its value after release until the next accepted press.
- Latency: with col stable from the start of a scan, key_valid fires DEBOUNCE_SCANS scans later plus 2 clocks.
- Glitch shorter than one scan: snapshot differs, stable_cnt restarts, key_map is unchanged, no event.
- Reset mid-scan or mid-debounce: everything returns to the reset values above; a key held across reset generates a fresh event after a full debounce.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in PRESSED, a scan counter counts end-of-scan events.
  - At REPEAT_DELAY, and every REPEAT_PERIOD scans after that, key_valid pulses again with the same key_code.
  - The counter clears on leaving PRESSED.
- Undefined: no repeat counter is synthesized; exactly one key_valid per press. REPEAT_* parameters are ignored.

Decomposition:
- Package keypad_pkg: KP_ROWS=4, KP_COLS=4, key_code_t (4-bit), event-FSM state enum {IDLE, PRESSED, LOCKED}.
- One sub-module, keypad_debounce: snapshot in, end-of-scan strobe in, stable_cnt/prev logic, key_map out.
- Scan counter, synchronizer and event FSM stay in keypad_scan.

Test Plan:
- Reset, col=4'b1111 -> row cycles 1110,1101,1011,0111 every 3 clocks; key_map=0; key_valid never asserts.
- Hold key (r=1,c=2): col[2]=0 while row[1]=0 -> key_map=16'h0040 and one key_valid pulse with key_code=4'h6 after 4 scans (~50 clocks); key_held stays 1. Release -> key_held=0 about 4 scans later.
- Key (2,0) bouncing every 5 clocks for 30 clocks, then stable -> no event during the bounce; exactly one key_valid with code 4'h8 after 4 stable scans.
- Keys (0,0) and (3,3) pressed together -> key_map=16'h8001, no key_valid. Release (3,3) only -> still LOCKED, no event. Release all, then press (0,1) -> key_valid with code 4'h1.
- Assert rst for 1 clock during debounce of key (1,1) still held -> outputs at reset values; key_valid with code 4'h5 about 4 scans after rst drops.
- With KEYPAD_REPEAT_EN, hold key (3,2) for 60 scans -> key_valid at debounce, then 40 scans later, then every 10 scans; all pulses carry code 4'hE.
